// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle controller: state encoding,
// instruction-class bit positions and exception cause codes.
package mc_pkg;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_MDU    = 3'd4,
      S_WB     = 3'd5,
      S_TRAP   = 3'd6
   } state_t;

   localparam int CLS_W      = 7;
   localparam int CLS_ALU    = 0;
   localparam int CLS_LOAD   = 1;
   localparam int CLS_STORE  = 2;
   localparam int CLS_BRANCH = 3;
   localparam int CLS_MDU    = 4;
   localparam int CLS_TRAP   = 5;
   localparam int CLS_ERET   = 6;

   localparam logic [CLS_W-1:0] OH_ALU    = 7'b1 << CLS_ALU;
   localparam logic [CLS_W-1:0] OH_LOAD   = 7'b1 << CLS_LOAD;
   localparam logic [CLS_W-1:0] OH_STORE  = 7'b1 << CLS_STORE;
   localparam logic [CLS_W-1:0] OH_BRANCH = 7'b1 << CLS_BRANCH;
   localparam logic [CLS_W-1:0] OH_MDU    = 7'b1 << CLS_MDU;
   localparam logic [CLS_W-1:0] OH_ERET   = 7'b1 << CLS_ERET;

   localparam logic [1:0] CAUSE_NONE = 2'b00;
   localparam logic [1:0] CAUSE_TRAP = 2'b01;
   localparam logic [1:0] CAUSE_ILL  = 2'b10;
   localparam logic [1:0] CAUSE_TMO  = 2'b11;

   function automatic logic is_onehot(input logic [CLS_W-1:0] c);
      return (c != '0) && ((c & (c - 7'd1)) == '0);
   endfunction

endpackage

// File: rtl/multicycle_ctrl_wait_cnt.sv
// Saturating wait counter shared by the memory-latency and MDU waits.
// Clear wins over enable; the count holds at all-ones instead of wrapping.
module wait_cnt #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                    cnt <= '0;
      else if (clr)               cnt <= '0;
      else if (en && cnt != '1)   cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle instruction-sequencing controller: FETCH/DECODE/EXEC plus
// memory and MDU wait states and a one-cycle exception (TRAP) state.
module multicycle_ctrl
   import mc_pkg::*;
#(
   parameter int MEM_LAT = 1,
   parameter int MDU_TMO = 40
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       run,
   input  logic [6:0] cls,
   input  logic       cond_ok,
   input  logic       mdu_busy,
   output logic       ir_we,
   output logic       pc_ena,
   output logic       r_we,
   output logic       d_e,
   output logic       d_we,
   output logic       mdu_start,
   output logic       exception,
   output logic       eret,
   output logic [1:0] cause,
   output logic [2:0] state
);

   localparam int CNT_MAX = (MEM_LAT > MDU_TMO) ? MEM_LAT : MDU_TMO;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] MEM_LAST = CW'(MEM_LAT - 1);
   localparam logic [CW-1:0] TMO_CNT  = CW'(MDU_TMO);

   state_t            cur, nxt;
   logic [CLS_W-1:0]  cls_q;
   logic [1:0]        cause_q, cause_nxt;
   logic              cls_ld, cause_ld, cnt_clr, cnt_en;
   logic [CW-1:0]     cnt;

   wait_cnt #(.W(CW)) u_cnt (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .en  (cnt_en),
      .cnt (cnt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur     <= S_FETCH;
         cls_q   <= '0;
         cause_q <= CAUSE_NONE;
      end else begin
         cur <= nxt;
         if (cls_ld)   cls_q   <= cls;
         if (cause_ld) cause_q <= cause_nxt;
      end
   end

   always_comb begin
      nxt       = cur;
      ir_we     = 1'b0;
      pc_ena    = 1'b0;
      r_we      = 1'b0;
      d_e       = 1'b0;
      d_we      = 1'b0;
      mdu_start = 1'b0;
      exception = 1'b0;
      eret      = 1'b0;
      cause     = CAUSE_NONE;
      cls_ld    = 1'b0;
      cause_ld  = 1'b0;
      cause_nxt = CAUSE_NONE;
      cnt_clr   = 1'b0;
      cnt_en    = 1'b0;
      case (cur)
         S_FETCH: begin
            // reset parks the FSM in FETCH; keep ir_we quiet until release
            if (run && !rst) begin
               ir_we = 1'b1;
               nxt   = S_DECODE;
            end
         end
         S_DECODE: begin
            cls_ld = 1'b1;
            if (!is_onehot(cls)) begin
               nxt       = S_TRAP;
               cause_ld  = 1'b1;
               cause_nxt = CAUSE_ILL;
            end else if (cls[CLS_TRAP]) begin
               if (cond_ok) begin
                  nxt       = S_TRAP;
                  cause_ld  = 1'b1;
                  cause_nxt = CAUSE_TRAP;
               end else begin
                  pc_ena = 1'b1;
                  nxt    = S_FETCH;
               end
            end else begin
               nxt = S_EXEC;
            end
         end
         S_EXEC: begin
            case (cls_q)
               OH_ALU: nxt = S_WB;
               OH_LOAD, OH_STORE: begin
                  cnt_clr = 1'b1;
                  nxt     = S_MEM;
               end
               OH_BRANCH: begin
                  pc_ena = 1'b1;
                  nxt    = S_FETCH;
               end
               OH_ERET: begin
                  eret   = 1'b1;
                  pc_ena = 1'b1;
                  nxt    = S_FETCH;
               end
               OH_MDU: begin
                  mdu_start = 1'b1;
                  cnt_clr   = 1'b1;
                  nxt       = S_MDU;
               end
               default: nxt = S_FETCH;
            endcase
         end
         S_MEM: begin
            d_e    = 1'b1;
            d_we   = cls_q[CLS_STORE];
            cnt_en = 1'b1;
            if (cnt == MEM_LAST) begin
               if (cls_q[CLS_STORE]) begin
                  pc_ena = 1'b1;
                  nxt    = S_FETCH;
               end else begin
                  nxt = S_WB;
               end
            end
         end
         S_MDU: begin
            cnt_en = 1'b1;
            // count 0 is the first MDU cycle, where busy is not yet meaningful
            if (cnt != '0) begin
               if (!mdu_busy) begin
                  pc_ena = 1'b1;
                  nxt    = S_FETCH;
               end else if (cnt >= TMO_CNT) begin
                  cause_ld  = 1'b1;
                  cause_nxt = CAUSE_TMO;
                  nxt       = S_TRAP;
               end
            end
         end
         S_WB: begin
            r_we   = 1'b1;
            pc_ena = 1'b1;
            nxt    = S_FETCH;
         end
         S_TRAP: begin
            exception = 1'b1;
            pc_ena    = 1'b1;
            cause     = cause_q;
            nxt       = S_FETCH;
         end
         default: nxt = S_FETCH;
      endcase
   end

   assign state = cur;

endmodule
